alu_issue_ctrl: RTL and testbench

- Command sequencer directly upstream of TotalALU.
- Accepts one ALU command per valid/ready handshake and drives TotalALU's dataA, dataB, Signal and reset inputs.
- Times the multi-cycle MULTU and returns results (a hi word and a lo word for MULTU) on a valid/ready result port.
- Removes the bench-style hand timing (reset pulse, fixed wait, MFHI/MFLO) from everything upstream.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_issue_ctrl.sv | 145 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the TotalALU command sequencer: funct codes,
// sequencer state encodings and the single-cycle funct classifier.
package alu_pkg;

   localparam logic [5:0] FN_AND   = 6'd36;
   localparam logic [5:0] FN_OR    = 6'd37;
   localparam logic [5:0] FN_ADD   = 6'd32;
   localparam logic [5:0] FN_SUB   = 6'd34;
   localparam logic [5:0] FN_SLT   = 6'd42;
   localparam logic [5:0] FN_SRL   = 6'd2;
   localparam logic [5:0] FN_MULTU = 6'd25;
   localparam logic [5:0] FN_MFHI  = 6'd16;
   localparam logic [5:0] FN_MFLO  = 6'd18;

   typedef logic [3:0] state_t;

   localparam state_t ST_IDLE     = 4'd0;
   localparam state_t ST_EXEC     = 4'd1;
   localparam state_t ST_MUL_RST  = 4'd2;
   localparam state_t ST_MUL_WAIT = 4'd3;
   localparam state_t ST_MFHI     = 4'd4;
   localparam state_t ST_RESP_HI  = 4'd5;
   localparam state_t ST_MFLO     = 4'd6;
   localparam state_t ST_RESP_LO  = 4'd7;
   localparam state_t ST_RESP     = 4'd8;

   function automatic logic is_single_cycle(input logic [5:0] funct);
      case (funct)
         FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT, FN_SRL: is_single_cycle = 1'b1;
         default:                                       is_single_cycle = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// Sequencer in front of TotalALU: issues one command per handshake, times the
// MULTU reset/wait/MFHI/MFLO sequence and returns result words on a valid/ready port.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int MUL_CYCLES = 33,
   parameter int CNT_W      = $clog2(MUL_CYCLES + 1)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [5:0]  cmd_funct,
   input  logic [31:0] cmd_a,
   input  logic [31:0] cmd_b,
   output logic [31:0] alu_dataA,
   output logic [31:0] alu_dataB,
   output logic [5:0]  alu_signal,
   output logic        alu_reset,
   input  logic [31:0] alu_out,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,
   output logic        res_hi,
   output logic        res_err,
   output logic        busy,
   output logic [3:0]  dbg_state
);

   // Handshakes: a transfer happens on a rising clk edge where valid && ready;
   // valid-side payload is held stable until that edge.

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      data_a_q, data_a_d;
   logic [31:0]      data_b_q, data_b_d;
   logic [5:0]       signal_q, signal_d;
   logic [31:0]      res_data_q, res_data_d;
   logic             res_hi_q, res_hi_d;
   logic             res_err_q, res_err_d;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      data_a_d   = data_a_q;
      data_b_d   = data_b_q;
      signal_d   = signal_q;
      res_data_d = res_data_q;
      res_hi_d   = res_hi_q;
      res_err_d  = res_err_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               if (is_single_cycle(cmd_funct) || cmd_funct == FN_MULTU) begin
                  data_a_d = cmd_a;
                  data_b_d = cmd_b;
                  signal_d = cmd_funct;
                  state_d  = (cmd_funct == FN_MULTU) ? ST_MUL_RST : ST_EXEC;
               end else begin
                  // Unsupported funct: leave the ALU side untouched, answer with an error word.
                  res_err_d  = 1'b1;
                  res_data_d = '0;
                  res_hi_d   = 1'b0;
                  state_d    = ST_RESP;
               end
            end
         end
         ST_EXEC: begin
            res_data_d = alu_out;
            res_err_d  = 1'b0;
            res_hi_d   = 1'b0;
            state_d    = ST_RESP;
         end
         ST_MUL_RST: begin
            cnt_d   = '0;
            state_d = ST_MUL_WAIT;
         end
         ST_MUL_WAIT: begin
            if (cnt_q == CNT_W'(MUL_CYCLES - 1)) begin
               signal_d = FN_MFHI;
               state_d  = ST_MFHI;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_MFHI: begin
            res_data_d = alu_out;
            res_hi_d   = 1'b1;
            res_err_d  = 1'b0;
            state_d    = ST_RESP_HI;
         end
         ST_RESP_HI: begin
            if (res_ready) begin
               signal_d = FN_MFLO;
               state_d  = ST_MFLO;
            end
         end
         ST_MFLO: begin
            res_data_d = alu_out;
            res_hi_d   = 1'b0;
            state_d    = ST_RESP_LO;
         end
         ST_RESP, ST_RESP_LO: begin
            if (res_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         data_a_q   <= '0;
         data_b_q   <= '0;
         signal_q   <= '0;
         res_data_q <= '0;
         res_hi_q   <= 1'b0;
         res_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         data_a_q   <= data_a_d;
         data_b_q   <= data_b_d;
         signal_q   <= signal_d;
         res_data_q <= res_data_d;
         res_hi_q   <= res_hi_d;
         res_err_q  <= res_err_d;
      end
   end

   // The ALU's own reset follows ours combinationally so it clears with us.
   assign alu_reset  = reset | (state_q == ST_MUL_RST);
   assign cmd_ready  = (state_q == ST_IDLE);
   assign busy       = (state_q != ST_IDLE);
   assign res_valid  = (state_q == ST_RESP) || (state_q == ST_RESP_HI) || (state_q == ST_RESP_LO);
   assign alu_dataA  = data_a_q;
   assign alu_dataB  = data_b_q;
   assign alu_signal = signal_q;
   assign res_data   = res_data_q;
   assign res_hi     = res_hi_q;
   assign res_err    = res_err_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl driving a behavioural TotalALU model.
module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [5:0]  cmd_funct = '0;
   logic [31:0] cmd_a = '0;
   logic [31:0] cmd_b = '0;
   logic [31:0] alu_dataA, alu_dataB, alu_out;
   logic [5:0]  alu_signal;
   logic        alu_reset;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [31:0] res_data;
   logic        res_hi, res_err, busy;
   logic [3:0]  dbg_state;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   alu_issue_ctrl dut (
      .clk(clk), .reset(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_funct(cmd_funct),
      .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_dataA(alu_dataA), .alu_dataB(alu_dataB), .alu_signal(alu_signal),
      .alu_reset(alu_reset), .alu_out(alu_out),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_hi(res_hi), .res_err(res_err), .busy(busy), .dbg_state(dbg_state)
   );

   // TotalALU stand-in: MULTU result lands after 32 cycles of Signal=25 following reset.
   logic [31:0] m_hi, m_lo;
   int          m_cnt;
   logic [63:0] m_prod;
   assign m_prod = {32'b0, alu_dataA} * {32'b0, alu_dataB};

   always @(posedge clk) begin
      if (alu_reset) begin
         m_hi <= '0; m_lo <= '0; m_cnt <= 0;
      end else if (alu_signal == 6'd25) begin
         if (m_cnt == 31) {m_hi, m_lo} <= m_prod;
         m_cnt <= m_cnt + 1;
      end
   end

   always_comb begin
      alu_out = '0;
      case (alu_signal)
         6'd36: alu_out = alu_dataA & alu_dataB;
         6'd37: alu_out = alu_dataA | alu_dataB;
         6'd32: alu_out = alu_dataA + alu_dataB;
         6'd34: alu_out = alu_dataA - alu_dataB;
         6'd42: alu_out = ($signed(alu_dataA) < $signed(alu_dataB)) ? 32'd1 : 32'd0;
         6'd2:  alu_out = alu_dataA >> alu_dataB[4:0];
         6'd16: alu_out = m_hi;
         6'd18: alu_out = m_lo;
         default: alu_out = '0;
      endcase
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic send(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_funct = f; cmd_a = a; cmd_b = b;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   // Returns the number of negedges after the accept until res_valid (limit+1 on timeout).
   task automatic wait_valid(input int limit, output int k);
      k = limit + 1;
      for (int i = 1; i <= limit; i++) begin
         @(negedge clk);
         if (res_valid) begin k = i; break; end
      end
   endtask

   task automatic consume();
      res_ready = 1'b1;
      @(posedge clk);
      #1 res_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      tests_run++; if (alu_reset !== 1'b1) begin tests_failed++; $display("FAIL reset_alu_reset: got %0b want 1", alu_reset); end
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      tests_run++; if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_cmd_ready: got %0b want 1", cmd_ready); end
      tests_run++; if (busy !== 1'b0 || res_valid !== 1'b0 || alu_reset !== 1'b0) begin tests_failed++;
         $display("FAIL reset_flags: busy=%0b res_valid=%0b alu_reset=%0b want 0 0 0", busy, res_valid, alu_reset); end
      tests_run++; if (alu_dataA !== 32'd0 || alu_dataB !== 32'd0 || alu_signal !== 6'd0) begin tests_failed++;
         $display("FAIL reset_alu_side: A=%0h B=%0h sig=%0d want 0 0 0", alu_dataA, alu_dataB, alu_signal); end
      tests_run++; if (res_data !== 32'd0 || res_hi !== 1'b0 || res_err !== 1'b0) begin tests_failed++;
         $display("FAIL reset_res: data=%0h hi=%0b err=%0b want 0 0 0", res_data, res_hi, res_err); end
   endtask

   task automatic test_add();
      int k;
      send(6'd32, 32'd7, 32'd5);
      wait_valid(10, k);
      tests_run++; if (k !== 2) begin tests_failed++; $display("FAIL add_latency: got %0d want 2", k); end
      tests_run++; if (res_data !== 32'd12 || res_hi !== 1'b0 || res_err !== 1'b0) begin tests_failed++;
         $display("FAIL add_result: data=%0d hi=%0b err=%0b want 12 0 0", res_data, res_hi, res_err); end
      tests_run++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin tests_failed++;
         $display("FAIL add_busy: cmd_ready=%0b busy=%0b want 0 1", cmd_ready, busy); end
      consume();
      @(negedge clk);
      tests_run++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin tests_failed++;
         $display("FAIL add_return_idle: cmd_ready=%0b res_valid=%0b want 1 0", cmd_ready, res_valid); end
   endtask

   task automatic test_sub_slt();
      int k;
      send(6'd34, 32'd5, 32'd7);
      wait_valid(10, k);
      tests_run++; if (k !== 2 || res_data !== 32'd4294967294) begin tests_failed++;
         $display("FAIL sub_result: lat=%0d data=%0d want 2 4294967294", k, res_data); end
      consume();
      send(6'd42, 32'd3, 32'd9);
      wait_valid(10, k);
      tests_run++; if (k !== 2 || res_data !== 32'd1 || res_err !== 1'b0) begin tests_failed++;
         $display("FAIL slt_result: lat=%0d data=%0d err=%0b want 2 1 0", k, res_data, res_err); end
      consume();
   endtask

   task automatic test_error();
      int k;
      send(6'd27, 32'd9, 32'd3);
      wait_valid(10, k);
      tests_run++; if (k !== 1) begin tests_failed++; $display("FAIL err_latency: got %0d want 1", k); end
      tests_run++; if (res_err !== 1'b1 || res_data !== 32'd0 || res_hi !== 1'b0) begin tests_failed++;
         $display("FAIL err_result: err=%0b data=%0h hi=%0b want 1 0 0", res_err, res_data, res_hi); end
      tests_run++; if (alu_dataA !== 32'd3 || alu_dataB !== 32'd9 || alu_signal !== 6'd42) begin tests_failed++;
         $display("FAIL err_alu_untouched: A=%0d B=%0d sig=%0d want 3 9 42", alu_dataA, alu_dataB, alu_signal); end
      consume();
      @(negedge clk);
      tests_run++; if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL err_return_idle: got %0b want 1", cmd_ready); end
   endtask

   task automatic test_multu();
      int k, n_rst, n_sig;
      n_rst = 0; n_sig = 0; k = 61;
      send(6'd25, 32'd65536, 32'd65536);
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (alu_reset) n_rst++;
         if (alu_signal == 6'd25) n_sig++;
         if (res_valid) begin k = i; break; end
      end
      tests_run++; if (k !== 36) begin tests_failed++; $display("FAIL mul_hi_latency: got %0d want 36", k); end
      tests_run++; if (n_rst !== 1) begin tests_failed++; $display("FAIL mul_alu_reset_cycles: got %0d want 1", n_rst); end
      tests_run++; if (n_sig !== 34) begin tests_failed++; $display("FAIL mul_signal25_cycles: got %0d want 34", n_sig); end
      tests_run++; if (res_data !== 32'd1 || res_hi !== 1'b1 || res_err !== 1'b0) begin tests_failed++;
         $display("FAIL mul_hi_word: data=%0d hi=%0b err=%0b want 1 1 0", res_data, res_hi, res_err); end
      consume();
      wait_valid(10, k);
      tests_run++; if (k !== 2 || res_data !== 32'd0 || res_hi !== 1'b0) begin tests_failed++;
         $display("FAIL mul_lo_word: lat=%0d data=%0d hi=%0b want 2 0 0", k, res_data, res_hi); end
      consume();
      @(negedge clk);
      tests_run++; if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL mul_return_idle: got %0b want 1", cmd_ready); end
   endtask

   task automatic test_backpressure();
      int k;
      send(6'd25, 32'hFFFF_FFFF, 32'd2);
      wait_valid(60, k);
      tests_run++; if (k !== 36) begin tests_failed++; $display("FAIL bp_hi_latency: got %0d want 36", k); end
      cmd_valid = 1'b1; cmd_funct = 6'd32; cmd_a = 32'd100; cmd_b = 32'd200;
      for (int i = 0; i < 10; i++) begin
         tests_run++;
         if (res_valid !== 1'b1 || res_data !== 32'd1 || res_hi !== 1'b1 || cmd_ready !== 1'b0 || alu_signal !== 6'd16) begin
            tests_failed++;
            $display("FAIL bp_hold_%0d: valid=%0b data=%0d hi=%0b cmd_ready=%0b sig=%0d want 1 1 1 0 16",
                     i, res_valid, res_data, res_hi, cmd_ready, alu_signal);
         end
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      consume();
      wait_valid(10, k);
      tests_run++; if (k !== 2 || res_data !== 32'd4294967294 || res_hi !== 1'b0) begin tests_failed++;
         $display("FAIL bp_lo_word: lat=%0d data=%0d hi=%0b want 2 4294967294 0", k, res_data, res_hi); end
      tests_run++; if (alu_dataA !== 32'hFFFF_FFFF) begin tests_failed++;
         $display("FAIL bp_cmd_ignored: A=%0h want ffffffff", alu_dataA); end
      consume();
   endtask

   task automatic test_reset_mid_mul();
      int k;
      send(6'd25, 32'd12345, 32'd678);
      repeat (11) @(posedge clk);
      @(negedge clk);
      tests_run++; if (dbg_state !== 4'd3) begin tests_failed++; $display("FAIL rstmul_in_wait: state=%0d want 3", dbg_state); end
      rst = 1'b1;
      #1;
      tests_run++; if (alu_reset !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin tests_failed++;
         $display("FAIL rstmul_flags: alu_reset=%0b busy=%0b res_valid=%0b want 1 0 0", alu_reset, busy, res_valid); end
      tests_run++; if (alu_dataA !== 32'd0 || alu_dataB !== 32'd0 || alu_signal !== 6'd0 || res_data !== 32'd0 || res_hi !== 1'b0 || res_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL rstmul_zero: A=%0h B=%0h sig=%0d data=%0h hi=%0b err=%0b want all 0",
                  alu_dataA, alu_dataB, alu_signal, res_data, res_hi, res_err); end
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      tests_run++; if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL rstmul_cmd_ready: got %0b want 1", cmd_ready); end
      send(6'd32, 32'd1, 32'd1);
      wait_valid(10, k);
      tests_run++; if (k !== 2 || res_data !== 32'd2) begin tests_failed++;
         $display("FAIL rstmul_add_after: lat=%0d data=%0d want 2 2", k, res_data); end
      consume();
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub_slt();
      test_error();
      test_multu();
      test_backpressure();
      test_reset_mid_mul();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
